// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller running register-to-register ALU ops over a single-read-port register file.
// Optional build macro ALU_SEQ_SAME_REG_SKIP_EN: skip RD_B when rs1 == rs2 on the register path.
module alu_op_sequencer #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic              cmd_use_imm,
  input  logic [WIDTH-1:0]  cmd_imm,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [WIDTH-1:0]  rf_rd_data,
  output logic [ADDR_W-1:0] rf_we_addr,
  output logic [WIDTH-1:0]  rf_we_data,
  output logic              rf_we,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [2:0]        alu_control,
  input  logic [WIDTH-1:0]  alu_res,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic [CNT_W-1:0]  op_count,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_A = 3'd1;
  localparam logic [2:0] S_RD_B = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;

  // Handshake: a command transfers on a posedge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, and cmd_* is ignored in every other state.

  logic [2:0]        state_q,   state_d;
  logic [2:0]        op_q,      op_d;
  logic [ADDR_W-1:0] rs1_q,     rs1_d;
  logic [ADDR_W-1:0] rs2_q,     rs2_d;
  logic [ADDR_W-1:0] rd_q,      rd_d;
  logic              use_imm_q, use_imm_d;
  logic [WIDTH-1:0]  imm_q,     imm_d;
  logic [WIDTH-1:0]  opa_q,     opa_d;
  logic [WIDTH-1:0]  opb_q,     opb_d;
  logic [WIDTH-1:0]  res_q,     res_d;
  logic [WIDTH-1:0]  result_q,  result_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [WIDTH-1:0]  alu_a_q,   alu_a_d;
  logic [WIDTH-1:0]  alu_b_q,   alu_b_d;
  logic [2:0]        alu_ctl_q, alu_ctl_d;
  logic [WIDTH-1:0]  exec_b;

  assign exec_b = use_imm_q ? imm_q : opb_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    use_imm_d = use_imm_q;
    imm_d     = imm_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_ctl_d = alu_ctl_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d      = cmd_op;
          rs1_d     = cmd_rs1;
          rs2_d     = cmd_rs2;
          rd_d      = cmd_rd;
          use_imm_d = cmd_use_imm;
          imm_d     = cmd_imm;
          state_d   = S_RD_A;
        end
      end
      S_RD_A: begin
        opa_d = rf_rd_data;
        if (use_imm_q) begin
          state_d = S_EXEC;
        end
`ifdef ALU_SEQ_SAME_REG_SKIP_EN
        else if (rs1_q == rs2_q) begin
          opb_d   = rf_rd_data;
          state_d = S_EXEC;
        end
`endif
        else begin
          state_d = S_RD_B;
        end
      end
      S_RD_B: begin
        opb_d   = rf_rd_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // Keep a copy of the ALU drive so the ALU inputs hold after EXEC.
        res_d     = alu_res;
        alu_a_d   = opa_q;
        alu_b_d   = exec_b;
        alu_ctl_d = op_q;
        state_d   = S_WB;
      end
      S_WB: begin
        result_d = res_q;
        cnt_d    = cnt_q + CNT_W'(1);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_ctl_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      use_imm_q <= use_imm_d;
      imm_q     <= imm_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      res_q     <= res_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_ctl_q <= alu_ctl_d;
    end
  end

  // Write strobe and done are pure state decodes, so they cannot glitch outside WB.
  assign cmd_ready   = (state_q == S_IDLE);
  assign rf_we       = (state_q == S_WB);
  assign done        = (state_q == S_WB);
  assign rf_we_addr  = rd_q;
  assign rf_we_data  = res_q;
  assign rf_rd_addr  = (state_q == S_RD_B) ? rs2_q : rs1_q;
  assign alu_a       = (state_q == S_EXEC) ? opa_q : alu_a_q;
  assign alu_b       = (state_q == S_EXEC) ? exec_b : alu_b_q;
  assign alu_control = (state_q == S_EXEC) ? op_q : alu_ctl_q;
  assign result      = result_q;
  assign op_count    = cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU and register file around the DUT, scoreboard of writes.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_rs1, cmd_rs2, cmd_rd;
  logic       cmd_use_imm;
  logic [3:0] cmd_imm;
  logic [1:0] rf_rd_addr;
  logic [3:0] rf_rd_data;
  logic [1:0] rf_we_addr;
  logic [3:0] rf_we_data;
  logic       rf_we;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_control;
  logic [3:0] alu_res;
  logic       done;
  logic [3:0] result;
  logic [7:0] op_count;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  logic [3:0] rf [4] = '{default: 4'h0};
  logic [3:0] sh_rf [4] = '{default: 4'h0};

  logic [3:0] exp_q[$];
  logic [1:0] exp_rd_q[$];
  logic [1:0] exp_rs1_q[$];
  logic [2:0] exp_op_q[$];
  logic [3:0] exp_a_q[$];
  logic [3:0] exp_b_q[$];
  int         exp_lat_q[$];

  alu_op_sequencer #(.WIDTH(4), .ADDR_W(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
    .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .rf_we_addr(rf_we_addr), .rf_we_data(rf_we_data), .rf_we(rf_we),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_res(alu_res),
    .done(done), .result(result), .op_count(op_count), .dbg_state(dbg_state)
  );

  // Clock and environment models
  always #5 clk = ~clk;

  function automatic logic [3:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return ~(a & b);
      3'd2: return a | b;
      3'd3: return ~(a | b);
      3'd4: return a + b;
      3'd5: return a - b;
      3'd6: return ($signed(a) < $signed(b)) ? 4'h1 : 4'h0;
      default: return 4'h0;
    endcase
  endfunction

  assign alu_res    = alu_f(alu_control, alu_a, alu_b);
  assign rf_rd_data = rf[rf_rd_addr];

  always @(negedge clk) begin
    if (rf_we) rf[rf_we_addr] <= rf_we_data;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int exp_latency(input logic use_imm, input logic [1:0] rs1, input logic [1:0] rs2);
    if (use_imm) return 3;
`ifdef ALU_SEQ_SAME_REG_SKIP_EN
    if (rs1 == rs2) return 3;
`endif
    return 4;
  endfunction

  // Driver: present a command and push its expected write to the scoreboard.
  task automatic push_cmd(input logic [2:0] op, input logic [1:0] rs1, input logic [1:0] rs2,
                          input logic [1:0] rd, input logic use_imm, input logic [3:0] imm);
    logic [3:0] a, b, r;
    a = sh_rf[rs1];
    b = use_imm ? imm : sh_rf[rs2];
    r = alu_f(op, a, b);
    sh_rf[rd] = r;
    exp_q.push_back(r);
    exp_rd_q.push_back(rd);
    exp_rs1_q.push_back(rs1);
    exp_op_q.push_back(op);
    exp_a_q.push_back(a);
    exp_b_q.push_back(b);
    exp_lat_q.push_back(exp_latency(use_imm, rs1, rs2));
    cmd_op = op; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd;
    cmd_use_imm = use_imm; cmd_imm = imm;
    cmd_valid = 1'b1;
  endtask

  // Called just after an accept edge; waits for done and checks the write-back.
  task automatic wait_done();
    int lat;
    bit got;
    logic [3:0] e_res, e_a, e_b;
    logic [1:0] e_rd, e_rs1;
    logic [2:0] e_op;
    int e_lat;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 16) begin
      @(negedge clk);
      lat++;
      checks++;
      if (cmd_ready !== 1'b0) begin
        errors++; $display("FAIL busy_ready: got %b want 0 at cycle %0d", cmd_ready, lat);
      end
      if (done === 1'b1) got = 1'b1;
      else begin
        checks++;
        if (rf_we !== 1'b0) begin
          errors++; $display("FAIL rf_we_outside_wb: got %b want 0 at cycle %0d", rf_we, lat);
        end
      end
    end
    e_res = exp_q.pop_front();   e_rd = exp_rd_q.pop_front();
    e_rs1 = exp_rs1_q.pop_front(); e_op = exp_op_q.pop_front();
    e_a = exp_a_q.pop_front();   e_b = exp_b_q.pop_front();
    e_lat = exp_lat_q.pop_front();
    checks++;
    if (!got) begin
      errors++; $display("FAIL done_timeout: no done within %0d cycles", lat);
      return;
    end
    if (lat != e_lat) begin
      errors++; $display("FAIL latency: got %0d want %0d", lat, e_lat);
    end
    checks++;
    if (rf_we !== 1'b1) begin
      errors++; $display("FAIL rf_we_in_wb: got %b want 1", rf_we);
    end
    checks++;
    if (rf_we_addr !== e_rd) begin
      errors++; $display("FAIL we_addr: got %0d want %0d", rf_we_addr, e_rd);
    end
    checks++;
    if (rf_we_data !== e_res) begin
      errors++; $display("FAIL we_data: got %h want %h", rf_we_data, e_res);
    end
    checks++;
    if (alu_control !== e_op || alu_a !== e_a || alu_b !== e_b) begin
      errors++; $display("FAIL alu_hold: got ctl %0d a %h b %h want ctl %0d a %h b %h",
                         alu_control, alu_a, alu_b, e_op, e_a, e_b);
    end
    @(posedge clk); #1;
    exp_cnt++;
    checks++;
    if (result !== e_res) begin
      errors++; $display("FAIL result: got %h want %h", result, e_res);
    end
    checks++;
    if (op_count !== 8'(exp_cnt)) begin
      errors++; $display("FAIL op_count: got %0d want %0d", op_count, 8'(exp_cnt));
    end
    checks++;
    if (rf[e_rd] !== e_res) begin
      errors++; $display("FAIL rf_commit: r%0d got %h want %h", e_rd, rf[e_rd], e_res);
    end
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL idle_after_wb: got ready %b done %b want 1 0", cmd_ready, done);
    end
    checks++;
    if (rf_rd_addr !== e_rs1) begin
      errors++; $display("FAIL rd_addr_idle: got %0d want %0d", rf_rd_addr, e_rs1);
    end
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [1:0] rs1, input logic [1:0] rs2,
                         input logic [1:0] rd, input logic use_imm, input logic [3:0] imm);
    @(negedge clk);
    push_cmd(op, rs1, rs2, rd, use_imm, imm);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_done();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_rs1 = 2'd0; cmd_rs2 = 2'd0; cmd_rd = 2'd0;
    cmd_use_imm = 1'b0; cmd_imm = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rf_we !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got ready %b we %b done %b want 1 0 0", cmd_ready, rf_we, done);
    end
    checks++;
    if (result !== 4'h0 || op_count !== 8'h0) begin
      errors++; $display("FAIL reset_regs: got result %h count %0d want 0 0", result, op_count);
    end
    checks++;
    if (alu_a !== 4'h0 || alu_b !== 4'h0 || alu_control !== 3'd0 || rf_rd_addr !== 2'd0) begin
      errors++; $display("FAIL reset_latches: got a %h b %h ctl %0d rd %0d want 0", alu_a, alu_b, alu_control, rf_rd_addr);
    end
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_imm_add();
    run_cmd(3'd4, 2'd0, 2'd0, 2'd1, 1'b1, 4'h5);
    checks++;
    if (rf[1] !== 4'h5 || result !== 4'h5 || op_count !== 8'd1) begin
      errors++; $display("FAIL imm_add: got r1 %h result %h count %0d want 5 5 1", rf[1], result, op_count);
    end
  endtask

  task automatic test_reg_sub();
    run_cmd(3'd4, 2'd0, 2'd0, 2'd2, 1'b1, 4'h7);
    run_cmd(3'd5, 2'd1, 2'd2, 2'd3, 1'b0, 4'h0);
    checks++;
    if (rf[3] !== 4'hE) begin
      errors++; $display("FAIL reg_sub: got r3 %h want e", rf[3]);
    end
  endtask

  task automatic test_slt_zero();
    run_cmd(3'd6, 2'd1, 2'd2, 2'd0, 1'b0, 4'h0);
    checks++;
    if (result !== 4'h1) begin errors++; $display("FAIL slt_r1_r2: got %h want 1", result); end
    run_cmd(3'd6, 2'd2, 2'd1, 2'd0, 1'b0, 4'h0);
    checks++;
    if (result !== 4'h0) begin errors++; $display("FAIL slt_r2_r1: got %h want 0", result); end
    run_cmd(3'd6, 2'd3, 2'd1, 2'd0, 1'b0, 4'h0);
    checks++;
    if (result !== 4'h1) begin errors++; $display("FAIL slt_neg: got %h want 1", result); end
    run_cmd(3'd7, 2'd1, 2'd0, 2'd0, 1'b1, 4'h9);
    checks++;
    if (rf[0] !== 4'h0 || result !== 4'h0) begin
      errors++; $display("FAIL zero_op: got r0 %h result %h want 0 0", rf[0], result);
    end
  endtask

  task automatic test_back_to_back();
    int cnt_before;
    cnt_before = exp_cnt;
    @(negedge clk);
    push_cmd(3'd0, 2'd1, 2'd2, 2'd3, 1'b0, 4'h0);
    @(posedge clk); #1;
    // Valid stays high; the new fields must not disturb the op in flight.
    push_cmd(3'd2, 2'd3, 2'd0, 2'd3, 1'b1, 4'hA);
    wait_done();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_accept: got ready %b want 0", cmd_ready);
    end
    wait_done();
    checks++;
    if (op_count !== 8'(cnt_before + 2) || rf[3] !== 4'hF) begin
      errors++; $display("FAIL b2b_total: got count %0d r3 %h want %0d f", op_count, rf[3], 8'(cnt_before + 2));
    end
  endtask

  task automatic test_reset_abort();
    logic [3:0] saved_r2;
    saved_r2 = rf[2];
    @(negedge clk);
    cmd_op = 3'd4; cmd_rs1 = 2'd0; cmd_rs2 = 2'd1; cmd_rd = 2'd2; cmd_use_imm = 1'b0; cmd_imm = 4'h0;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL abort_rd_a_we: got %b want 0", rf_we); end
    @(negedge clk);
    checks++;
    if (dbg_state !== 3'd2) begin errors++; $display("FAIL abort_in_rd_b: got state %0d want 2", dbg_state); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 0;
    checks++;
    if (cmd_ready !== 1'b1 || result !== 4'h0 || op_count !== 8'd0) begin
      errors++; $display("FAIL abort_state: got ready %b result %h count %0d want 1 0 0", cmd_ready, result, op_count);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b0) begin errors++; $display("FAIL abort_we: got %b want 0 cycle %0d", rf_we, i); end
    end
    checks++;
    if (rf[2] !== saved_r2) begin
      errors++; $display("FAIL abort_r2: got %h want %h", rf[2], saved_r2);
    end
  endtask

  task automatic test_same_reg();
    run_cmd(3'd4, 2'd0, 2'd0, 2'd1, 1'b1, 4'h5);
    run_cmd(3'd4, 2'd1, 2'd1, 2'd1, 1'b0, 4'h0);
    checks++;
    if (rf[1] !== 4'hA) begin errors++; $display("FAIL same_reg: got r1 %h want a", rf[1]); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      run_cmd(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic test_count_wrap();
    while (exp_cnt < 256) begin
      run_cmd(3'd4, 2'($urandom_range(0, 3)), 2'd0, 2'($urandom_range(0, 3)), 1'b1,
              4'($urandom_range(0, 15)));
    end
    checks++;
    if (op_count !== 8'd0) begin errors++; $display("FAIL count_wrap: got %0d want 0", op_count); end
  endtask

  initial begin
    test_reset();
    test_imm_add();
    test_reg_sub();
    test_slt_zero();
    test_back_to_back();
    test_reset_abort();
    test_same_reg();
    test_random();
    test_count_wrap();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
